// File: rtl/avalon_mem_responder.sv
// ---------------------------------------------------------------------------
// avalon_mem_responder
//
// Avalon-MM responder that stands in for a DDR3 controller local interface.
// Single and burst writes land in an on-chip array; reads are returned through
// a fixed-latency pipe so traffic generators see realistic read timing without
// the hard controller being present.
//
// Optional feature macro: AVL_RANDOM_STALL_EN
//   When defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) adds pseudo-random
//   waitrequest stalls in IDLE/WBURST whenever lfsr[1:0] == 2'b00.
//   When undefined, waitrequest follows the FSM only.
//
// Ports
//   iCLK              in   1       clock, all logic on posedge
//   iRST_n            in   1       asynchronous active-low reset
//   local_init_done   out  1       calibration-done emulation, sticky high
//   avl_address       in   ADDR_W  word address, sampled on first beat only
//   avl_write         in   1       write request
//   avl_read          in   1       read request
//   avl_writedata     in   DATA_W  write data
//   avl_burstbegin    in   1       first-beat marker, informational only
//   avl_size          in   8       burst length in beats
//   avl_waitrequest   out  1       1 = request not accepted this cycle
//   avl_readdata      out  DATA_W  read data
//   avl_readdatavalid out  1       avl_readdata valid this cycle
//   wr_beat_cnt       out  32      accepted write beats, saturating
//   rd_beat_cnt       out  32      returned read beats, saturating
//   protocol_err      out  1       sticky protocol violation flag
// ---------------------------------------------------------------------------
module avalon_mem_responder #(
  parameter int          ADDR_W      = 26,
  parameter int          DATA_W      = 128,
  parameter int          MEM_AW      = 10,
  parameter int          RD_LAT      = 4,
  parameter int          INIT_CYCLES = 64,
  parameter logic [15:0] STALL_SEED  = 16'hACE1
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  output logic              local_init_done,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_write,
  input  logic              avl_read,
  input  logic [DATA_W-1:0] avl_writedata,
  input  logic              avl_burstbegin,
  input  logic [7:0]        avl_size,
  output logic              avl_waitrequest,
  output logic [DATA_W-1:0] avl_readdata,
  output logic              avl_readdatavalid,
  output logic [31:0]       wr_beat_cnt,
  output logic [31:0]       rd_beat_cnt,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WBURST = 2'd2,
    ST_RBURST = 2'd3
  } state_t;

  localparam int                INIT_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [31:0]       CNT_MAX   = 32'hFFFF_FFFF;
  localparam logic [MEM_AW-1:0] ADDR_ONE  = MEM_AW'(1);

  // Storage array: deliberately never reset.
  logic [DATA_W-1:0] mem [2**MEM_AW];

  state_t              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic                init_done_q, init_done_d;
  logic                wait_q, wait_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [7:0]          rem_q, rem_d;
  logic                perr_q, perr_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;
  logic [31:0]         rd_cnt_q, rd_cnt_d;
  logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_data_q [RD_LAT];
  logic [DATA_W-1:0]   rd_data_d [RD_LAT];

  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                mem_we_s;
  logic [MEM_AW-1:0]   mem_waddr_s;
  logic [DATA_W-1:0]   mem_rdata_s;
  logic                rd_issue_s;
  logic                stall_s;
  logic                unused_s;

  // Write wins over a simultaneous read; the read is dropped and flagged.
  assign wr_acc_s    = avl_write & ~wait_q;
  assign rd_acc_s    = avl_read & ~avl_write & ~wait_q;
  assign mem_rdata_s = mem[addr_q];

  // Inputs that carry no function here (upper address bits, burstbegin).
  assign unused_s = ^{avl_burstbegin, avl_address[ADDR_W-1:MEM_AW], STALL_SEED};

`ifdef AVL_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR step; stall decision uses next value so the registered
  // waitrequest lines up with the LFSR state of the same cycle.
  always_comb begin
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    stall_s = (lfsr_d[1:0] == 2'b00);
  end

  // LFSR state register, seeded at reset.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall_s = 1'b0;
`endif

  // FSM next-state, array write control, burst bookkeeping and error flag.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    perr_d      = perr_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr_q;
    rd_issue_s  = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
      end

      ST_IDLE: begin
        if (wr_acc_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = avl_address[MEM_AW-1:0];
          if (avl_read || (avl_size == 8'd0)) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
          if (avl_size > 8'd1) begin
            addr_d  = avl_address[MEM_AW-1:0] + ADDR_ONE;
            rem_d   = avl_size - 8'd1;
            state_d = ST_WBURST;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (rd_acc_s) begin
          addr_d  = avl_address[MEM_AW-1:0];
          state_d = ST_RBURST;
          // A zero-length burst is treated as a single beat.
          if (avl_size == 8'd0) begin
            rem_d  = 8'd1;
            perr_d = 1'b1;
          end else begin
            rem_d = avl_size;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WBURST: begin
        // Address and size are ignored on continuation beats.
        if (avl_read && !wait_q) begin
          perr_d = 1'b1;
        end else begin
          perr_d = perr_q;
        end
        if (wr_acc_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = addr_q;
          addr_d      = addr_q + ADDR_ONE;
          rem_d       = rem_q - 8'd1;
          if (rem_q <= 8'd1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WBURST;
          end
        end else begin
          state_d = ST_WBURST;
        end
      end

      ST_RBURST: begin
        rd_issue_s = 1'b1;
        addr_d     = addr_q + ADDR_ONE;
        rem_d      = rem_q - 8'd1;
        if (rem_q <= 8'd1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RBURST;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Registered waitrequest derived from the state being entered.
  always_comb begin
    case (state_d)
      ST_INIT:   wait_d = 1'b1;
      ST_RBURST: wait_d = 1'b1;
      ST_IDLE:   wait_d = stall_s;
      ST_WBURST: wait_d = stall_s;
      default:   wait_d = 1'b1;
    endcase
  end

  // Saturating beat counters.
  always_comb begin
    if (mem_we_s && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (rd_vld_q[RD_LAT-1] && (rd_cnt_q != CNT_MAX)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Read latency pipe: stage 0 loads on beat issue, last stage drives the port.
  always_comb begin
    rd_vld_d     = {RD_LAT{1'b0}};
    rd_vld_d[0]  = rd_issue_s;
    rd_data_d[0] = rd_issue_s ? mem_rdata_s : {DATA_W{1'b0}};
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_data_d[i] = rd_data_q[i-1];
    end
  end

  // Control and status registers.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= {INIT_W{1'b0}};
      init_done_q <= 1'b0;
      wait_q      <= 1'b1;
      addr_q      <= {MEM_AW{1'b0}};
      rem_q       <= 8'd0;
      perr_q      <= 1'b0;
      wr_cnt_q    <= 32'd0;
      rd_cnt_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      perr_q      <= perr_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  // Read pipe registers; reset flushes any in-flight beats.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rd_vld_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        rd_data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      rd_vld_q <= rd_vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_data_q[i] <= rd_data_d[i];
      end
    end
  end

  // Array write port.
  always_ff @(posedge iCLK) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= avl_writedata;
    end
  end

  assign local_init_done   = init_done_q;
  assign avl_waitrequest   = wait_q;
  assign avl_readdata      = rd_data_q[RD_LAT-1];
  assign avl_readdatavalid = rd_vld_q[RD_LAT-1];
  assign wr_beat_cnt       = wr_cnt_q;
  assign rd_beat_cnt       = rd_cnt_q;
  assign protocol_err      = perr_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_avalon_mem_responder
//
// Directed bench with a read-data scoreboard: read stimulus pushes expected
// words into a queue, and an independent monitor pops and compares whenever
// avl_readdatavalid is seen.
// ---------------------------------------------------------------------------
module tb_avalon_mem_responder;

  localparam int ADDR_W      = 26;
  localparam int DATA_W      = 128;
  localparam int MEM_AW      = 10;
  localparam int RD_LAT      = 4;
  localparam int INIT_CYCLES = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              local_init_done;
  logic [ADDR_W-1:0] avl_address = '0;
  logic              avl_write = 1'b0;
  logic              avl_read = 1'b0;
  logic [DATA_W-1:0] avl_writedata = '0;
  logic              avl_burstbegin = 1'b0;
  logic [7:0]        avl_size = 8'd0;
  logic              avl_waitrequest;
  logic [DATA_W-1:0] avl_readdata;
  logic              avl_readdatavalid;
  logic [31:0]       wr_beat_cnt;
  logic [31:0]       rd_beat_cnt;
  logic              protocol_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] exp_q [$];
  int                vcyc_q [$];
  logic [DATA_W-1:0] mon_exp;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  avalon_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW),
    .RD_LAT(RD_LAT), .INIT_CYCLES(INIT_CYCLES), .STALL_SEED(16'hACE1)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .local_init_done(local_init_done),
    .avl_address(avl_address), .avl_write(avl_write), .avl_read(avl_read),
    .avl_writedata(avl_writedata), .avl_burstbegin(avl_burstbegin),
    .avl_size(avl_size), .avl_waitrequest(avl_waitrequest),
    .avl_readdata(avl_readdata), .avl_readdatavalid(avl_readdatavalid),
    .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt),
    .protocol_err(protocol_err)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid beat must match the oldest expectation.
  always @(negedge clk) begin
    if (avl_readdatavalid === 1'b1) begin
      vcyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("rd_unexpected_beat", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", avl_readdata, mon_exp);
      end
    end
  end

  // One accepted transfer; entered and left on a negedge.
  task automatic bus_cmd(input logic wr, input logic rd, input logic [ADDR_W-1:0] addr,
                         input logic [7:0] size, input logic [DATA_W-1:0] data,
                         output int acc_cyc);
    int  n;
    bit  done;
    avl_write      = wr;
    avl_read       = rd;
    avl_address    = addr;
    avl_size       = size;
    avl_writedata  = data;
    avl_burstbegin = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      done = (avl_waitrequest === 1'b0);
      @(negedge clk);
      n++;
    end
    if (!done) check("cmd_accept_timeout", 0, 1);
    acc_cyc        = cyc;
    avl_write      = 1'b0;
    avl_read       = 1'b0;
    avl_burstbegin = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Reset plus reset-state and init-timing checks; returns on a negedge.
  task automatic do_reset();
    int bad;
    avl_write = 1'b0;
    avl_read  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_readdatavalid", avl_readdatavalid, 0);
    repeat (3) @(negedge clk);
    check("rst_waitrequest", avl_waitrequest, 1);
    check("rst_init_done", local_init_done, 0);
    check("rst_wr_cnt", wr_beat_cnt, 0);
    check("rst_rd_cnt", rd_beat_cnt, 0);
    check("rst_protocol_err", protocol_err, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 1; i < INIT_CYCLES; i++) begin
      @(negedge clk);
      if (local_init_done !== 1'b0 || avl_waitrequest !== 1'b1) bad++;
    end
    check("init_hold_violations", bad, 0);
    @(negedge clk);
    check("init_done_rise", local_init_done, 1);
    check("init_waitrequest_low", avl_waitrequest, 0);
  endtask

  logic [DATA_W-1:0] a5;
  int acc;

  initial begin
    a5 = {16{8'hA5}};
    repeat (2) @(negedge clk);

    // 1: reset and init timing
    do_reset();

    // 2: single write then single read, latency check
    bus_cmd(1'b1, 1'b0, 26'h010, 8'd1, a5, acc);
    exp_q.push_back(a5);
    vcyc_q.delete();
    bus_cmd(1'b0, 1'b1, 26'h010, 8'd1, '0, acc);
    drain();
    check("single_rd_latency", (vcyc_q.size() > 0) ? vcyc_q[0] : -1, acc + RD_LAT);
    check("single_wr_cnt", wr_beat_cnt, 1);
    check("single_rd_cnt", rd_beat_cnt, 1);

    // 3: wrapping burst write/read; continuation address/size must be ignored
    bus_cmd(1'b1, 1'b0, 26'h3FE, 8'd4, 128'd1, acc);
    bus_cmd(1'b1, 1'b0, 26'h123, 8'd9, 128'd2, acc);
    bus_cmd(1'b1, 1'b0, 26'h055, 8'd1, 128'd3, acc);
    bus_cmd(1'b1, 1'b0, 26'h000, 8'd0, 128'd4, acc);
    for (int i = 1; i <= 4; i++) exp_q.push_back(DATA_W'(i));
    vcyc_q.delete();
    bus_cmd(1'b0, 1'b1, 26'h3FE, 8'd4, '0, acc);
    drain();
    check("burst_rd_latency", (vcyc_q.size() > 0) ? vcyc_q[0] : -1, acc + RD_LAT);
    check("burst_gap_free", (vcyc_q.size() == 4) ? (vcyc_q[3] - vcyc_q[0]) : -1, 3);
    check("burst_wr_cnt", wr_beat_cnt, 5);
    check("burst_rd_cnt", rd_beat_cnt, 5);
    check("burst_no_err", protocol_err, 0);

    // idle cycles inside a write burst, with high address bits set
    bus_cmd(1'b1, 1'b0, 26'h2C00020, 8'd3, 128'h10, acc);
    bus_cmd(1'b1, 1'b0, 26'h0, 8'd0, 128'h11, acc);
    repeat (2) @(negedge clk);
    bus_cmd(1'b1, 1'b0, 26'h0, 8'd0, 128'h12, acc);
    exp_q.push_back(128'h10);
    exp_q.push_back(128'h11);
    exp_q.push_back(128'h12);
    bus_cmd(1'b0, 1'b1, 26'h020, 8'd3, '0, acc);
    drain();
    check("gap_wr_cnt", wr_beat_cnt, 8);
    check("gap_rd_cnt", rd_beat_cnt, 8);
    check("gap_no_err", protocol_err, 0);

    // 4a: write and read together -> write stored, error flagged
    bus_cmd(1'b1, 1'b1, 26'h050, 8'd1, 128'h77, acc);
    @(negedge clk);
    check("wr_rd_collision_err", protocol_err, 1);
    exp_q.push_back(128'h77);
    bus_cmd(1'b0, 1'b1, 26'h050, 8'd1, '0, acc);
    drain();
    check("collision_wr_cnt", wr_beat_cnt, 9);
    check("collision_rd_cnt", rd_beat_cnt, 9);

    // 4b: size=0 write is one beat and flags an error
    do_reset();
    bus_cmd(1'b1, 1'b0, 26'h060, 8'd0, 128'h88, acc);
    @(negedge clk);
    check("size0_err", protocol_err, 1);
    bus_cmd(1'b1, 1'b0, 26'h070, 8'd1, 128'h99, acc);
    exp_q.push_back(128'h88);
    exp_q.push_back(128'h99);
    bus_cmd(1'b0, 1'b1, 26'h060, 8'd1, '0, acc);
    bus_cmd(1'b0, 1'b1, 26'h070, 8'd1, '0, acc);
    drain();
    check("size0_wr_cnt", wr_beat_cnt, 2);
    check("size0_rd_cnt", rd_beat_cnt, 2);

    // 5: reset in the middle of an 8-beat read burst; no beat may follow
    bus_cmd(1'b0, 1'b1, 26'h3FE, 8'd8, '0, acc);
    @(negedge clk);
    do_reset();
    repeat (12) @(negedge clk);
    check("post_abort_rd_cnt", rd_beat_cnt, 0);
    check("post_abort_wr_cnt", wr_beat_cnt, 0);

    // array survives reset
    exp_q.push_back(a5);
    bus_cmd(1'b0, 1'b1, 26'h010, 8'd1, '0, acc);
    drain();
    check("post_reset_rd_cnt", rd_beat_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
